// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin arbiter slice.
// Holds only the width helper that keeps the interface and top in agreement.
package rr_arb_pkg;

  // A single requester still needs a one-bit index port.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// All arbiter outputs are combinational from arbiter state and i_req.
interface rr_arb_if #(
  parameter int W = 4
);
  import rr_arb_pkg::*;

  localparam int IDX_W = idx_width(W);

  logic [W-1:0]     i_req;
  logic             i_ack;
  logic             i_lock;
  logic [W-1:0]     o_gnt;
  logic             o_gnt_vld;
  logic [IDX_W-1:0] o_gnt_enc;
  logic             o_locked;

  modport master (
    output i_req, i_ack, i_lock,
    input  o_gnt, o_gnt_vld, o_gnt_enc, o_locked
  );

  modport slave (
    input  i_req, i_ack, i_lock,
    output o_gnt, o_gnt_vld, o_gnt_enc, o_locked
  );

endinterface

// File: rtl/rr_arb_pri.sv
// Fixed-priority one-hot selector; purely combinational, zero latency.
// FROM_LSB picks the lowest set bit, otherwise the highest set bit.
module rr_arb_pri #(
  parameter int W        = 4,
  parameter bit FROM_LSB = 1'b1
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    if (FROM_LSB) begin
      for (int i = 0; i < W; i++) begin
        if (req_i[i] && !found) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (req_i[i] && !found) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter with optional grant lock; grant is 0-cycle from i_req.
// State advances only on i_ack with a valid grant; otherwise everything holds.
module rr_arb
  import rr_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic    clk,
  input  logic    arst_n,
  rr_arb_if.slave bus
);

  localparam int IDX_W = idx_width(W);

  logic [W-1:0]     mask_q, mask_d;
  logic [W-1:0]     lock_gnt_q;
  logic             lock_q;
  logic [W-1:0]     masked_req, pick_m, pick_r, gnt;
  logic [W-1:0]     above;
  logic             lock_hit, take, seen;
  logic [IDX_W-1:0] enc;

  assign masked_req = bus.i_req & mask_q;

  rr_arb_pri #(.W(W), .FROM_LSB(1'b1)) u_pri_masked (
    .req_i (masked_req),
    .gnt_o (pick_m)
  );

  rr_arb_pri #(.W(W), .FROM_LSB(1'b1)) u_pri_raw (
    .req_i (bus.i_req),
    .gnt_o (pick_r)
  );

  // A lock only counts while the held requester is still asking.
  always_comb begin
    lock_hit = lock_q & (|(bus.i_req & lock_gnt_q));
    if (lock_hit) begin
      gnt = lock_gnt_q;
    end else if (|masked_req) begin
      gnt = pick_m;
    end else begin
      gnt = pick_r;
    end
  end

  always_comb begin
    enc = '0;
    for (int i = 0; i < W; i++) begin
      if (gnt[i]) begin
        enc = enc | IDX_W'(i);
      end
    end
  end

  assign take = bus.i_ack & (|gnt);

  // Mask keeps only requesters strictly above the winner; top winner wraps.
  always_comb begin
    above = '0;
    seen  = 1'b0;
    for (int i = 0; i < W; i++) begin
      above[i] = seen;
      seen     = seen | gnt[i];
    end
    if (gnt[W-1]) begin
      above = '1;
    end
    mask_d = take ? above : mask_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mask_q     <= '1;
      lock_q     <= 1'b0;
      lock_gnt_q <= '0;
    end else begin
      mask_q <= mask_d;
      if (take) begin
        lock_q <= bus.i_lock;
        if (bus.i_lock) begin
          lock_gnt_q <= gnt;
        end
      end else if (lock_q && !lock_hit) begin
        lock_q <= 1'b0;
      end
    end
  end

  assign bus.o_gnt     = gnt;
  assign bus.o_gnt_vld = |gnt;
  assign bus.o_gnt_enc = enc;
  assign bus.o_locked  = lock_hit;

endmodule

// File: tb/tb_rr_arb.sv
// Directed and random checks for rr_arb with W=4.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_rr_arb;

  localparam int W = 4;

  logic clk;
  logic arst_n;
  int   checks = 0;
  int   errors = 0;
  int   waitc [W];

  rr_arb_if #(.W(W)) bus ();

  rr_arb #(.W(W)) u_dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [W-1:0] r, input logic a, input logic l);
    @(negedge clk);
    bus.i_req  = r;
    bus.i_ack  = a;
    bus.i_lock = l;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] g, input logic [1:0] e,
                            input logic lk);
    chk({tag, ".gnt"}, 32'(bus.o_gnt), 32'(g));
    chk({tag, ".enc"}, 32'(bus.o_gnt_enc), 32'(e));
    chk({tag, ".vld"}, 32'(bus.o_gnt_vld), 32'(|g));
    chk({tag, ".locked"}, 32'(bus.o_locked), 32'(lk));
  endtask

  task automatic do_reset;
    @(negedge clk);
    bus.i_req  = '0;
    bus.i_ack  = 1'b0;
    bus.i_lock = 1'b0;
    arst_n     = 1'b0;
    @(negedge clk);
    arst_n     = 1'b1;
  endtask

  // Protocol invariants on every rising edge.
  always @(posedge clk) begin
    chk("onehot0", 32'($onehot0(bus.o_gnt)), 32'd1);
    chk("subset", 32'((bus.o_gnt & ~bus.i_req) == '0), 32'd1);
    chk("vld_eq_anyreq", 32'(bus.o_gnt_vld), 32'(|bus.i_req));
  end

  initial begin
    logic [W-1:0] r;
    logic         a;

    arst_n     = 1'b0;
    bus.i_req  = '0;
    bus.i_ack  = 1'b0;
    bus.i_lock = 1'b0;
    #1;
    expect_out("rst_idle", 4'b0000, 2'd0, 1'b0);
    bus.i_req = 4'b1111;
    #1;
    expect_out("rst_req", 4'b0001, 2'd0, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;

    // 1: full rotation with ack every cycle
    drive(4'b1111, 1'b1, 1'b0); expect_out("t1a", 4'b0001, 2'd0, 1'b0);
    drive(4'b1111, 1'b1, 1'b0); expect_out("t1b", 4'b0010, 2'd1, 1'b0);
    drive(4'b1111, 1'b1, 1'b0); expect_out("t1c", 4'b0100, 2'd2, 1'b0);
    drive(4'b1111, 1'b1, 1'b0); expect_out("t1d", 4'b1000, 2'd3, 1'b0);
    drive(4'b1111, 1'b1, 1'b0); expect_out("t1e", 4'b0001, 2'd0, 1'b0);

    // 2: sparse requests wrap past index 3
    do_reset();
    drive(4'b1010, 1'b1, 1'b0); expect_out("t2a", 4'b0010, 2'd1, 1'b0);
    drive(4'b1010, 1'b1, 1'b0); expect_out("t2b", 4'b1000, 2'd3, 1'b0);
    drive(4'b1010, 1'b1, 1'b0); expect_out("t2c", 4'b0010, 2'd1, 1'b0);

    // 3: no ack holds the pointer
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0110, 1'b0, 1'b0); expect_out("t3hold", 4'b0010, 2'd1, 1'b0);
    end
    drive(4'b0110, 1'b1, 1'b0); expect_out("t3ack", 4'b0010, 2'd1, 1'b0);
    drive(4'b0110, 1'b0, 1'b0); expect_out("t3next", 4'b0100, 2'd2, 1'b0);

    // 4: lock holds grant across acks, release moves on
    do_reset();
    drive(4'b1111, 1'b1, 1'b0); expect_out("t4a", 4'b0001, 2'd0, 1'b0);
    drive(4'b1111, 1'b1, 1'b0); expect_out("t4b", 4'b0010, 2'd1, 1'b0);
    drive(4'b1111, 1'b1, 1'b1); expect_out("t4lock", 4'b0100, 2'd2, 1'b0);
    drive(4'b1111, 1'b1, 1'b1); expect_out("t4held1", 4'b0100, 2'd2, 1'b1);
    drive(4'b1111, 1'b1, 1'b1); expect_out("t4held2", 4'b0100, 2'd2, 1'b1);
    drive(4'b1111, 1'b1, 1'b0); expect_out("t4rel", 4'b0100, 2'd2, 1'b1);
    drive(4'b1111, 1'b0, 1'b0); expect_out("t4after", 4'b1000, 2'd3, 1'b0);

    // 5: held requester drops, lock falls through and clears
    do_reset();
    drive(4'b1111, 1'b1, 1'b0); expect_out("t5a", 4'b0001, 2'd0, 1'b0);
    drive(4'b1111, 1'b1, 1'b1); expect_out("t5lock", 4'b0010, 2'd1, 1'b0);
    drive(4'b1101, 1'b0, 1'b0); expect_out("t5drop", 4'b0100, 2'd2, 1'b0);
    drive(4'b1111, 1'b0, 1'b0); expect_out("t5cleared", 4'b0100, 2'd2, 1'b0);

    // 6: async reset while locked
    do_reset();
    drive(4'b1111, 1'b1, 1'b0);
    drive(4'b1111, 1'b1, 1'b0);
    drive(4'b1111, 1'b1, 1'b1); expect_out("t6lock", 4'b0100, 2'd2, 1'b0);
    drive(4'b1111, 1'b0, 1'b0); expect_out("t6held", 4'b0100, 2'd2, 1'b1);
    #2;
    arst_n = 1'b0;
    #1;
    expect_out("t6inrst", 4'b0001, 2'd0, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    drive(4'b1111, 1'b0, 1'b0); expect_out("t6post", 4'b0001, 2'd0, 1'b0);

    // Random: a held request is served within W acks.
    do_reset();
    for (int i = 0; i < W; i++) waitc[i] = 0;
    r = 4'b1011;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      end
      a = 1'($urandom_range(0, 1));
      drive(r, a, 1'b0);
      for (int i = 0; i < W; i++) begin
        if (!r[i]) begin
          waitc[i] = 0;
        end else if (a && bus.o_gnt_vld) begin
          if (bus.o_gnt[i]) begin
            waitc[i] = 0;
          end else begin
            waitc[i]++;
            chk("starve", 32'(waitc[i] < W), 32'd1);
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
